// File: rtl/iir_ff_stage_if.sv
// Sample/coefficient/result bus between upstream, the feedforward stage and the feedback stage.
// master drives samples and coefficient writes; slave is the filter stage.
interface iir_ff_stage_if #(
  parameter int PRECISION  = 16,
  parameter int COEF_WIDTH = 16
);
  logic signed [PRECISION-1:0]  x;
  logic                         x_valid;
  logic                         x_ready;
  logic                         coef_we;
  logic [3:0]                   coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic signed [PRECISION-1:0]  y;
  logic                         y_valid;

  modport master (
    output x, x_valid, coef_we, coef_addr, coef_data,
    input  x_ready, y, y_valid
  );

  modport slave (
    input  x, x_valid, coef_we, coef_addr, coef_data,
    output x_ready, y, y_valid
  );
endinterface

// File: rtl/iir_ff_stage.sv
// Feedforward (zeros) section of the IIR filter: y = sum b[k]*x[n-k], one shared MAC per clock,
// rounded half-up and saturated back to sample width.
module iir_ff_stage #(
  parameter int PRECISION  = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14,
  parameter int TAPS       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  iir_ff_stage_if.slave bus
);
  localparam int PW   = PRECISION + COEF_WIDTH;
  localparam int ACCW = PW + 4;
  localparam int KW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                            state, state_nxt;
  logic [TAPS-1:0][PRECISION-1:0]    d;
  logic [TAPS-1:0][COEF_WIDTH-1:0]   b;
  logic [KW-1:0]                     k;
  logic signed [ACCW-1:0]            acc;
  logic signed [PW-1:0]              prod;
  logic signed [ACCW-1:0]            rnd, shf;
  logic signed [PRECISION-1:0]       sat;
  logic                              accept, coef_ok;

  assign bus.x_ready = (state == IDLE);
  assign accept      = bus.x_valid && (state == IDLE);
  // Writes land only between samples; same-edge write + accept is seen by that sample's MAC pass.
  assign coef_ok     = bus.coef_we && (state == IDLE) && ({1'b0, bus.coef_addr} < 5'(TAPS));

  assign prod = PW'($signed(d[k])) * PW'($signed(b[k]));
  assign rnd  = acc + HALF;
  assign shf  = rnd >>> COEF_FRAC;

  always_comb begin
    sat = shf[PRECISION-1:0];
    if (shf > YMAX)      sat = YMAX[PRECISION-1:0];
    else if (shf < YMIN) sat = YMIN[PRECISION-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      d           <= '0;
      b           <= '0;
      acc         <= '0;
      k           <= '0;
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.y_valid <= (state == DONE);
      if (coef_ok) b[bus.coef_addr[KW-1:0]] <= bus.coef_data;
      case (state)
        IDLE: if (accept) begin
          d[0] <= bus.x;
          for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
          acc <= '0;
          k   <= '0;
        end
        MAC: begin
          acc <= acc + {{4{prod[PW-1]}}, prod};
          k   <= k + KW'(1);
        end
        DONE:    bus.y <= sat;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/iir_ff_stage.md
Name: iir_ff_stage

Overview:
Feedforward (numerator/zeros) stage of the configurable IIR filter. It pairs with iir_fb, which implements the feedback (pole) section of the same filter. It computes y[n] = sum over k of b[k]*x[n-k] with a tap delay line and one shared multiplier, running one multiply-accumulate per clock. Coefficients are programmable at run time. The output is rounded and saturated back to the sample precision, and y_valid signals each result to the feedback stage.

Parameters:
PRECISION, 16, sample width in bits (signed two's complement) for x and y.
COEF_WIDTH, 16, signed coefficient width.
COEF_FRAC, 14, fractional bits in coefficients (0x4000 = 1.0 at defaults).
TAPS, 4, number of feedforward taps, legal range 1..16.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
x  in  PRECISION  signed input sample
x_valid  in  1  input sample valid
x_ready  out  1  stage can accept a sample (high only in IDLE)
coef_we  in  1  coefficient write strobe
coef_addr  in  4  coefficient index k
coef_data  in  COEF_WIDTH  signed coefficient value
y  out  PRECISION  signed filtered output, registered
y_valid  out  1  one-cycle pulse, y holds a new result

Behaviour:
- One clock (clk); reset rst_n is synchronous and active-low. No asynchronous logic.
- Reset clears the following: state=IDLE; delay line d[0..TAPS-1]=0; all coefficients b[k]=0; accumulator=0; tap counter=0; y=0; y_valid=0. x_ready=1 in the cycle after reset.
- Reset asserted mid-operation aborts the computation, produces no y_valid, and clears everything above, including coefficients.
- FSM has three states: IDLE, MAC, DONE. x_ready = (state==IDLE), decoded combinationally from state.
- IDLE: on an edge with x_valid && x_ready (edge E0), shift the delay line (d[0]<=x, d[k]<=d[k-1]). Also set acc<=0 and k<=0, and go to MAC.
- MAC: at each of edges E1..E(TAPS), acc <= acc + d[k]*b[k] and k++. At E(TAPS), go to DONE.
- DONE: at E(TAPS+1), register y from acc, pulse y_valid=1, and return to IDLE.
- Latency: y_valid is high in the cycle following E(TAPS+1). x_ready is high in that same cycle.
- Throughput: one sample per TAPS+2 clocks (6 at defaults).
- y holds its value between results. y_valid is high for exactly one cycle per accepted sample.
- x_valid while x_ready=0 is ignored. The stage does not buffer samples; upstream must hold x_valid until it is accepted.
- Arithmetic:
  - Product is a full signed PRECISION+COEF_WIDTH-bit value.
  - acc is PRECISION+COEF_WIDTH+4 bits, sized for 16 taps, so it never overflows.
  - Result = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, an arithmetic shift (round half up).
  - Result is then saturated to [-2^(PRECISION-1), 2^(PRECISION-1)-1].
- Coefficient writes:
  - Committed only when state==IDLE and coef_addr < TAPS. All other writes are silently dropped, including writes during MAC or DONE.
  - coef_we and an accepted x_valid on the same IDLE edge: the write commits, and that sample's computation uses the new coefficient.
- The delay line persists across samples. It is not cleared by coefficient writes.

Test Plan:
1. Identity: write b0=0x4000, b1..b3=0. Send x=1000 -> y=1000, y_valid one cycle, 6 clocks after the accepting edge. x_ready is low for the 5 intervening cycles.
2. Impulse response: b=0x4000,0x2000,0x1000,0x0800. Send 1024,0,0,0 -> y=1024,512,256,128.
3. Saturation: b0=b1=0x7FFF, b2=b3=0. Send 30000,30000 -> second y=32767. Then send -32768,-32768 -> y=-32768.
4. Rounding: b0=0x2000, others 0. x=3 -> y=2; x=-3 -> y=-1; x=2 -> y=1.
5. Handshake and drops:
   - Hold x_valid high continuously -> exactly one sample accepted every 6 clocks, with y_valid pulses 6 clocks apart.
   - coef_we during MAC -> ignored.
   - coef_addr=7 in IDLE -> ignored.
   - Both dropped writes are confirmed by an unchanged y for a repeated input.
6. Reset mid-MAC: with b0=0x4000, drive rst_n low for one edge at E2 -> next cycle y=0, y_valid=0, x_ready=1, and no y_valid for the aborted sample. Then send x=1000 without reprogramming -> y=0.
